// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage multiply/divide sequencer with fixed-latency HI/LO commit
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        pend_hi_q, pend_lo_q, hi_q, lo_q;
    logic               div0_q;
    logic               cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    logic        is_muldiv, mul_signed, div_signed;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] ua, ub, q_u, r_u, quot, rem;

    assign is_muldiv  = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign mul_signed = (mdu_op == OP_MULT);
    assign div_signed = (mdu_op == OP_DIV);

    // Sign/zero-extend to 64 bits so a single truncated multiply serves both flavours
    assign a_ext   = mul_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign b_ext   = mul_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign product = a_ext * b_ext;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend
    assign ua   = (div_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign ub   = (div_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
    assign q_u  = (ub == 32'd0) ? 32'd0 : ua / ub;
    assign r_u  = (ub == 32'd0) ? 32'd0 : ua % ub;
    assign quot = (div_signed && (src_a[31] ^ src_b[31])) ? (32'd0 - q_u) : q_u;
    assign rem  = (div_signed && src_a[31]) ? (32'd0 - r_u) : r_u;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !cancel_w) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                {pend_hi_q, pend_lo_q} <= product;
                                div0_q  <= 1'b0;
                                cnt_q   <= CNT_W'(MULT_CYCLES - 1);
                                state_q <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= rem;
                                pend_lo_q <= quot;
                                div0_q    <= (src_b == 32'd0);
                                cnt_q     <= CNT_W'(DIV_CYCLES - 1);
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= src_a;
                            OP_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel_w) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pend_hi_q <= '0;
                        pend_lo_q <= '0;
                    end else if (cnt_q == '0) begin
                        if (!div0_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q == RUN);
    assign stall_req = busy | (start & is_muldiv);
endmodule
